// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Turns one decoded memory op into a single
// req/ack bus transaction. It steers byte/halfword lanes, generates write strobes and
// sign/zero-extends load data. The pipeline stays stalled until the access completes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of performing them aligned down.
module mem_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdo_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    // Last REQ cycle index before the access is abandoned.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [1:0]  lane;
    logic [2:0]  size_code;
    logic        start;
    logic        misaligned;
    logic        timed_out;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign start     = valid_i & (mem_re_i | mem_we_i);
    assign timed_out = (cnt == CntLast);
    // Gated by reset so the pipeline is released immediately while reset is held.
    assign stall_o   = rst & (((state == StIdle) & start) | (state == StReq));

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords must be 2-byte aligned; words (and unlisted codes) 4-byte aligned.
    always_comb begin
        misaligned = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr_i[0];
            default:        misaligned = |addr_i[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering: replicate data across lanes, strobe selects the live bytes.
    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = wdata_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                st_wstrb = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                st_wstrb = 4'b0011 << {addr_i[1], 1'b0};
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting: pick the lane from the latched offset, then extend.
    always_comb begin
        ld_byte = bus_rdata_i[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_code)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (start) begin
                    state_next = misaligned ? StDone : StReq;
                end
            end
            StReq: begin
                if (bus_ack_i || timed_out) begin
                    state_next = StDone;
                end
            end
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    // Request latch, timeout counter and registered result/pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            lane        <= '0;
            size_code   <= '0;
            rdo_o       <= '0;
            err_o       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wstrb_o <= '0;
            bus_wdata_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            err_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (start) begin
                        if (misaligned) begin
                            rdo_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_o <= 1'b1;
`endif
                        end else begin
                            cnt         <= '0;
                            lane        <= addr_i[1:0];
                            size_code   <= funct3_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_wstrb_o <= mem_we_i ? st_wstrb : 4'b0000;
                            bus_wdata_o <= st_wdata;
                        end
                    end
                end
                StReq: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        rdo_o     <= bus_we_o ? 32'b0 : ld_data;
                    end else if (timed_out) begin
                        bus_req_o <= 1'b0;
                        rdo_o     <= '0;
                        err_o     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed self-checking bench for mem_lsu. A per-op timeline
// model computes the expected outputs for each cycle; one negedge process compares them.
module tb_mem_lsu;

    localparam int unsigned TO = 6;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdo_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_lsu #(
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .mem_re_i   (mem_re_i),
        .mem_we_i   (mem_we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .stall_o    (stall_o),
        .rdo_o      (rdo_o),
        .err_o      (err_o),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_wstrb_o(bus_wstrb_o),
        .bus_wdata_o(bus_wdata_o),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o (misalign_o),
`endif
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    bit          chk_en;
    logic        exp_stall, exp_req, exp_err, exp_mis, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdo;
    logic [3:0]  exp_wstrb;
    logic [31:0] model_rdo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model functions: plain arithmetic on the size/lane rules.
    function automatic bit is_byte(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b100);
    endfunction

    function automatic bit is_half(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] off);
        if (is_byte(f3)) return 4'b0001 << off;
        if (is_half(f3)) return 4'b0011 << (2 * off[1]);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (is_byte(f3)) return {24'b0, w[7:0]} * 32'h0101_0101;
        if (is_half(f3)) return {16'b0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (is_byte(f3)) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (is_half(f3)) begin
            v = (rd >> (16 * off[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (is_byte(f3)) return 1'b0;
        if (is_half(f3)) return off[0];
        return off != 2'b00;
    endfunction

    // Per-cycle comparison against the timeline model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
            chk("bus_req", {31'b0, bus_req_o}, {31'b0, exp_req});
            chk("err", {31'b0, err_o}, {31'b0, exp_err});
            chk("rdo", rdo_o, exp_rdo);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
`endif
            if (exp_req) begin
                chk("bus_addr", bus_addr_o, exp_addr);
                chk("bus_we", {31'b0, bus_we_o}, {31'b0, exp_we});
                if (exp_we) begin
                    chk("bus_wstrb", {28'b0, bus_wstrb_o}, {28'b0, exp_wstrb});
                    chk("bus_wdata", bus_wdata_o, exp_wdata);
                end
            end
        end
    end

    // One non-memory cycle; starts and ends just after a rising edge.
    task automatic idle_cycle();
        if ($urandom_range(0, 1) == 1) begin
            valid_i  = 1'b0;
            mem_re_i = 1'($urandom);
            mem_we_i = 1'($urandom);
        end else begin
            valid_i  = 1'b1;
            mem_re_i = 1'b0;
            mem_we_i = 1'b0;
        end
        addr_i      = $urandom;
        wdata_i     = $urandom;
        funct3_i    = 3'($urandom);
        bus_ack_i   = 1'($urandom);
        bus_rdata_i = $urandom;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_rdo   = model_rdo;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // One memory op. d = REQ cycles before ack (d >= TO means ack never comes).
    task automatic run_op(input logic we, input logic re, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] w, input int d,
                          input logic [31:0] ack_rdata, input bit use_rdata,
                          input bit lit_on, input logic [31:0] lit_addr,
                          input logic [3:0] lit_wstrb, input logic [31:0] lit_wdata,
                          input logic [31:0] lit_rdo, input int lit_stall);
        int          n_req;
        int          stalls;
        bit          tmo;
        bit          mis;
        logic [31:0] rd_used;
        logic [31:0] new_rdo;
        stalls  = 0;
        rd_used = '0;
        mis     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = m_misaligned(f3, a[1:0]);
`endif
        tmo   = (d >= int'(TO)) && !mis;
        n_req = mis ? 0 : (tmo ? int'(TO) : d + 1);

        valid_i = 1'b1; mem_re_i = re; mem_we_i = we; funct3_i = f3;
        addr_i  = a; wdata_i = w;
        bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_rdo   = model_rdo;
        exp_addr  = {a[31:2], 2'b00};
        exp_we    = we;
        exp_wstrb = m_wstrb(f3, a[1:0]);
        exp_wdata = m_wdata(f3, w);
        @(negedge clk);
        stalls += int'(stall_o);

        for (int k = 0; k < n_req; k++) begin
            @(posedge clk); #1;
            addr_i      = $urandom;
            wdata_i     = $urandom;
            funct3_i    = 3'($urandom);
            bus_ack_i   = !tmo && (k == d);
            bus_rdata_i = (use_rdata && k == d) ? ack_rdata : $urandom;
            if (k == d) rd_used = bus_rdata_i;
            exp_req = 1'b1;
            @(negedge clk);
            stalls += int'(stall_o);
            if (lit_on && k == 0) begin
                chk("lit_bus_addr", bus_addr_o, lit_addr);
                chk("lit_bus_we", {31'b0, bus_we_o}, {31'b0, we});
                if (we) begin
                    chk("lit_bus_wstrb", {28'b0, bus_wstrb_o}, {28'b0, lit_wstrb});
                    chk("lit_bus_wdata", bus_wdata_o, lit_wdata);
                end
            end
        end

        new_rdo = (mis || tmo || we) ? 32'b0 : m_load(f3, a[1:0], rd_used);
        @(posedge clk); #1;
        valid_i = 1'($urandom); addr_i = $urandom; funct3_i = 3'($urandom);
        bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = tmo; exp_mis = mis;
        exp_rdo   = new_rdo;
        @(negedge clk);
        stalls += int'(stall_o);
        if (lit_on) begin
            chk("lit_rdo", rdo_o, lit_rdo);
            chk("lit_stall_cycles", 32'(stalls), 32'(lit_stall));
        end
        model_rdo = new_rdo;
        @(posedge clk); #1;
    endtask

    logic [2:0] st_codes [6];

    initial begin
        st_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        chk_en = 1'b0; total = 0; bad = 0; model_rdo = '0;
        exp_stall = 0; exp_req = 0; exp_err = 0; exp_mis = 0; exp_we = 0;
        exp_addr = 0; exp_wdata = 0; exp_rdo = 0; exp_wstrb = 0;
        valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h100; wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        // Reset state: a pending op must not stall while reset is held.
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_req", {31'b0, bus_req_o}, 32'h0);
        chk("rst_rdo", rdo_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wstrb", {28'b0, bus_wstrb_o}, 32'h0);
        valid_i = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Directed cases with hand-computed expectations.
        run_op(0, 1, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1,
               1, 32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 2);
        run_op(0, 1, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000, 1,
               1, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 2);
        run_op(0, 1, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, 1,
               1, 32'h100, 4'h0, 32'h0, 32'h0000_0080, 2);
        run_op(0, 1, 3'b101, 32'h102, 32'h0, 0, 32'h80FF_0000, 1,
               1, 32'h100, 4'h0, 32'h0, 32'h0000_80FF, 2);
        run_op(1, 0, 3'b000, 32'h101, 32'h0000_00AB, 0, 32'h0, 0,
               1, 32'h100, 4'b0010, 32'hABAB_ABAB, 32'h0, 2);
        run_op(1, 0, 3'b001, 32'h102, 32'h1234_5678, 0, 32'h0, 0,
               1, 32'h100, 4'b1100, 32'h5678_5678, 32'h0, 2);
        run_op(0, 1, 3'b010, 32'h200, 32'h0, 5, 32'h0BAD_F00D, 1,
               1, 32'h200, 4'h0, 32'h0, 32'h0BAD_F00D, 7);
        run_op(0, 1, 3'b010, 32'h300, 32'h0, 1000, 32'h0, 0,
               1, 32'h300, 4'h0, 32'h0, 32'h0, 1 + int'(TO));
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(0, 1, 3'b010, 32'h102, 32'h0, 0, 32'h1122_3344, 1,
               1, 32'h100, 4'h0, 32'h0, 32'h0, 1);
`else
        run_op(0, 1, 3'b010, 32'h102, 32'h0, 0, 32'h1122_3344, 1,
               1, 32'h100, 4'h0, 32'h0, 32'h1122_3344, 2);
`endif
        idle_cycle();

        // Randomized mix of ops and non-memory cycles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                logic       we;
                logic       re;
                logic [2:0] f3;
                int         d;
                int         r;
                we = 1'($urandom);
                re = we ? 1'($urandom) : 1'b1;
                f3 = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom);
                r  = $urandom_range(0, 7);
                if (r < 5)       d = $urandom_range(0, 2);
                else if (r == 5) d = int'(TO) - 1;
                else if (r == 6) d = int'(TO);
                else             d = $urandom_range(3, int'(TO) + 1);
                run_op(we, re, f3, $urandom, $urandom, d, 32'h0, 0,
                       0, 32'h0, 4'h0, 32'h0, 32'h0, 0);
            end
        end

        // Asynchronous reset in the middle of REQ.
        run_op(0, 1, 3'b010, 32'h0, 32'h0, 0, 32'h1234_5678, 1,
               1, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 2);
        valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h400; bus_ack_i = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
        exp_rdo = model_rdo; exp_addr = 32'h400; exp_we = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        exp_req = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, bus_req_o}, 32'h0);
        chk("mid_rst_stall", {31'b0, stall_o}, 32'h0);
        chk("mid_rst_rdo", rdo_o, 32'h0);
        @(posedge clk); #1;
        chk("held_rst_stall", {31'b0, stall_o}, 32'h0);
        chk("held_rst_req", {31'b0, bus_req_o}, 32'h0);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        model_rdo = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle_cycle();
        run_op(0, 1, 3'b001, 32'h502, 32'h0, 1, 32'h8001_7FFF, 1,
               1, 32'h500, 4'h0, 32'h0, 32'hFFFF_8001, 3);
        idle_cycle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
